uart_rx_param: RTL
==================

# uart_rx_param

Parametrised UART receiver with oversampled, majority-voted bit recovery, configurable frame format and a valid/ready output handshake. It sits between the serial `RX_in` pin and the byte-consuming logic. It replaces the fixed 8-bit shift/parity/stop chain with a single timing-accurate block. It reports parity, framing and overrun errors per frame.

## Interface
- `CLK_DIV`, 4: CLK cycles per oversample tick (≥2)
- `OVERSAMPLE`, 16: ticks per bit period (even, ≥8)
- `DATA_BITS`, 8: data bits per frame (5..9)
- `PARITY`, 1: 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1: 1 or 2
- `CLK`  in  1  system clock, all logic on rising edge
- `RST`  in  1  asynchronous, active-low reset
- `RX_in`  in  1  serial line, idle high, asynchronous to CLK
- `RX_out`  out  DATA_BITS  received data, LSB = first bit on the line
- `rx_valid`  out  1  `RX_out` and the error flags hold a frame
- `rx_ready`  in  1  consumer accepts the frame when `rx_valid && rx_ready`
- `parity_error`  out  1  parity mismatch for the held frame (0 when PARITY=0)
- `stop_error`  out  1  at least one stop bit sampled low for the held frame
- `overrun_error`  out  1  one-cycle pulse: a completed frame was dropped
- `busy`  out  1  receiver not in IDLE

## Operation
- Input synchroniser: two flops, both reset to 1. All logic uses the synchronised line `rxs`.
- Tick generator: counter 0..CLK_DIV-1, free-running. `tick` is asserted for one cycle when the count equals CLK_DIV-1.
- Bit timing: `tcnt` counts ticks 0..OVERSAMPLE-1 within a bit.
- Samples are taken at ticks M-1, M and M+1, where M = OVERSAMPLE/2.
- The bit value is the 2-of-3 majority, decided on tick M+1.
- States and transitions:
  - IDLE: on `tick` with `rxs`=0 → START, with `tcnt`=1 (the detecting tick counts as tick 0).
  - START: if the majority at M+1 is 1 → IDLE (glitch rejected, nothing reported). Otherwise, at `tcnt`=OVERSAMPLE-1 → DATA.
  - DATA: shift the majority value in LSB-first. After DATA_BITS bits → PARITY if PARITY≠0, else STOP.
  - PARITY: compare the received bit with the XOR of the data bits (even), or its inverse (odd). A mismatch sets the frame's parity flag. End of bit → STOP.
  - STOP: STOP_BITS bits; any 0 sets the frame's stop flag. The frame completes at the majority point (M+1) of the last stop bit, not at the end of the bit, so back-to-back frames resynchronise. Then → IDLE if the stop flag is clear, else → BREAK.
  - BREAK: stay until `rxs`=1 on a tick, then → IDLE. A held-low line therefore yields exactly one frame.
- Output register, loaded on frame completion: `RX_out`, `parity_error`, `stop_error`, and `rx_valid` set to 1.
  - Held stable while `rx_valid && !rx_ready`.
  - `rx_valid` clears on handshake if no frame completes in the same cycle.
- Frame completes while `rx_valid=1` and `rx_ready=0`: the new frame is discarded, the old one is kept, and `overrun_error`=1 for that cycle.
- Frame completes in the same cycle as a handshake: the new frame is loaded, `rx_valid` stays 1, no overrun.
- Frames with errors are still delivered, with their flags.
- `busy` = (state ≠ IDLE).

## Timing
- Reset (RST=0, immediate, async): state IDLE, all counters 0, synchroniser 1.
  - Outputs: `RX_out`=0, `rx_valid`=0, `parity_error`=0, `stop_error`=0, `overrun_error`=0, `busy`=0.
- Reset asserted mid-frame discards the partial frame. After release, the receiver waits for a fresh falling edge seen on a tick.
- Bit period = CLK_DIV·OVERSAMPLE cycles (64 at defaults).
- Start detection latency: 2 cycles of synchroniser plus up to CLK_DIV cycles of tick phase.
- `rx_valid` rises 1 cycle after the completion tick. With the start edge at t=0, that is ≈ (1+DATA_BITS+P+STOP_BITS-1)·bit period + (M+1)·CLK_DIV cycles, plus the detection latency, where P=1 if parity is enabled.
- Tolerates ±(M-2)/OVERSAMPLE of a bit of accumulated drift at the last sample; that is ≥3% baud mismatch at defaults for a 10/11-bit frame.
- `overrun_error` is never asserted for more than one cycle per dropped frame.

## Test plan
- Defaults, send 0xA5 at the exact baud, even parity bit 0, stop 1, `rx_ready`=1 → one `rx_valid` cycle, `RX_out`=0xA5, both error flags 0, `busy` back to 0.
- Same frame with parity bit 1 → `RX_out`=0xA5, `parity_error`=1, `stop_error`=0. Repeat with PARITY=2 and parity bit 1 → no error.
- Low pulse of 12 cycles (3 ticks) on the idle line → `busy` pulses, then returns to 0. No `rx_valid`, no error flags.
- 0x00 with the stop bit low, then the line held low for 10 bit periods before going high → exactly one frame: `RX_out`=0x00, `stop_error`=1. Then `busy`=0, and the next 0x5A is received cleanly.
- `rx_ready`=0, send 0x3C then 0xC3 back-to-back → `RX_out` stays 0x3C, `rx_valid`=1, `overrun_error` pulses once. Raise `rx_ready` → handshake, `rx_valid`=0.
- DATA_BITS=7, STOP_BITS=2, baud 3% slow, and RST pulsed low mid-data on the first frame → that frame produces no output. The following 0x55 frame gives `RX_out`=0x55 with no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with 2-of-3 majority bit recovery,
// configurable frame format and a valid/ready output register.
//
// Ports:
//   CLK            system clock, rising edge
//   RST            asynchronous active-low reset
//   RX_in          serial line, idle high, asynchronous to CLK
//   RX_out         received data, LSB = first bit on the line
//   rx_valid       RX_out and error flags hold a frame
//   rx_ready       consumer accepts on rx_valid && rx_ready
//   parity_error   parity mismatch of the held frame
//   stop_error     a stop bit of the held frame sampled low
//   overrun_error  one-cycle pulse when a completed frame is dropped
//   busy           receiver not idle
module uart_rx_param #(
    parameter int CLK_DIV    = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX_in,
    output logic [DATA_BITS-1:0] RX_out,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_error,
    output logic                 stop_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int M  = OVERSAMPLE / 2;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_S0     = TW'(M - 1);
    localparam logic [TW-1:0] T_S1     = TW'(M);
    localparam logic [TW-1:0] T_MID    = TW'(M + 1);
    localparam logic [TW-1:0] T_END    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                 rx_s1;
    logic                 rxs;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 smp_a;
    logic                 smp_b;
    logic                 maj;
    logic                 mid_tick;
    logic                 end_tick;
    logic                 last_stop;
    logic                 par_ref;
    logic                 par_bad;
    logic                 par_err;
    logic                 stp_err;
    logic                 armed;
    logic                 frame_done;
    logic                 frame_stp;

    // Two-flop synchroniser; idles high so reset never looks like a start.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= RX_in;
            rxs   <= rx_s1;
        end
    end

    // Free-running oversample tick.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick     = (div_cnt == DIV_LAST);
    assign mid_tick = tick && (tcnt == T_MID);
    assign end_tick = tick && (tcnt == T_END);

    // Third vote is the live line at tick M+1.
    assign maj = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);

    assign last_stop = (STOP_BITS == 1) || stop_cnt;

    assign par_ref = (PARITY == 2) ? ~(^shreg) : ^shreg;
    assign par_bad = (PARITY != 0) && (maj != par_ref);

    // FSM: state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (tick && armed && !rxs) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (mid_tick && maj) begin
                    state_nxt = S_IDLE;
                end else if (end_tick) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (end_tick && (bit_cnt == B_LAST)) begin
                    state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (end_tick) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Complete at the vote point so the next start edge is caught.
                if (mid_tick && last_stop) begin
                    state_nxt = (stp_err || !maj) ? S_BREAK : S_IDLE;
                end
            end
            S_BREAK: begin
                if (tick && rxs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state != S_IDLE);
        frame_done = (state == S_STOP) && mid_tick && last_stop;
        frame_stp  = stp_err | ~maj;
    end

    // Bit timing, sampling and frame assembly.
    // armed requires the line to be seen high after reset, so a reset
    // in the middle of a frame cannot resynchronise on a data zero.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tcnt     <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            smp_a    <= 1'b1;
            smp_b    <= 1'b1;
            par_err  <= 1'b0;
            stp_err  <= 1'b0;
            armed    <= 1'b0;
        end else if (tick) begin
            unique case (state)
                S_IDLE: begin
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    par_err  <= 1'b0;
                    stp_err  <= 1'b0;
                    if (rxs) begin
                        armed <= 1'b1;
                    end
                    // Detecting tick is tick 0 of the start bit.
                    tcnt <= (armed && !rxs) ? T_ONE : '0;
                end
                S_BREAK: begin
                    tcnt <= '0;
                end
                default: begin
                    tcnt <= (tcnt == T_END) ? '0 : tcnt + 1'b1;
                    if (tcnt == T_S0) begin
                        smp_a <= rxs;
                    end
                    if (tcnt == T_S1) begin
                        smp_b <= rxs;
                    end
                    if (tcnt == T_MID) begin
                        if (state == S_DATA) begin
                            shreg <= {maj, shreg[DATA_BITS-1:1]};
                        end
                        if (state == S_PARITY) begin
                            par_err <= par_bad;
                        end
                        if ((state == S_STOP) && !maj) begin
                            stp_err <= 1'b1;
                        end
                    end
                    if (tcnt == T_END) begin
                        if (state == S_DATA) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (state == S_STOP) begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    if ((state_nxt == S_IDLE) || (state_nxt == S_BREAK)) begin
                        tcnt <= '0;
                    end
                end
            endcase
        end
    end

    // Output register: a pending frame wins over a new one unless it is
    // being accepted in the same cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RX_out        <= '0;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            stop_error    <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            overrun_error <= frame_done && rx_valid && !rx_ready;
            if (frame_done && (!rx_valid || rx_ready)) begin
                RX_out       <= shreg;
                parity_error <= par_err;
                stop_error   <= frame_stp;
                rx_valid     <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
